mem_access_ctrl: RTL and testbench

MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

---
 rtl/mem_access_ctrl.sv | 213 +++++++++++++++++++++
 tb/tb_mem_access_ctrl.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: sequences one CPU load/store into one or two word-wide
// memory transactions. A misaligned halfword (size=01, addr[1:0]=11)
// straddles two words. It is split into a high-lane access at the first
// word and a low-lane access at the following word.
//
// Ports
//   clk, rst        : rising-edge clock; asynchronous active-high reset
//   cpu_req         : access request, sampled only while idle
//   cpu_we          : 1 = store, 0 = load
//   cpu_size        : 00 byte, 01 half, 10 word
//   cpu_addr        : byte address
//   cpu_we4         : lane enables (already lane-rotated)
//   cpu_wdata       : store data (already lane-rotated)
//   cpu_busy        : access in flight
//   cpu_done        : one-cycle completion pulse
//   cpu_rdata       : raw lane-ordered load word
//   mem_req         : memory request
//   mem_addr        : memory word address
//   mem_we4         : memory lane write enables (0000 = read)
//   mem_wdata       : memory write data
//   mem_gnt         : memory accepts the request this cycle
//   mem_rvalid      : read data valid
//   mem_rdata       : memory read data
// All outputs are registers and are loaded from next-state values, so they
// line up with the state they belong to.
module mem_access_ctrl #(
  parameter int MEM_AW = 30
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [1:0]        cpu_size,
  input  logic [31:0]       cpu_addr,
  input  logic [3:0]        cpu_we4,
  input  logic [31:0]       cpu_wdata,
  output logic              cpu_busy,
  output logic              cpu_done,
  output logic [31:0]       cpu_rdata,
  output logic              mem_req,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [3:0]        mem_we4,
  output logic [31:0]       mem_wdata,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [31:0]       mem_rdata
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ISSUE1 = 3'd1,
    WAIT1  = 3'd2,
    ISSUE2 = 3'd3,
    WAIT2  = 3'd4,
    DONE   = 3'd5
  } state_t;

  localparam logic [MEM_AW-1:0] ADDR_ONE = {{(MEM_AW-1){1'b0}}, 1'b1};

  state_t              state_r, state_s;
  logic                we_r, split_r;
  logic [3:0]          we4_r;
  logic [31:0]         wdata_r, first_r;
  logic [MEM_AW-1:0]   addr1_r;

  // Values of the access being sequenced: the live CPU inputs while idle,
  // so outputs for ISSUE1 can be loaded on the accepting edge.
  logic                src_we_s, src_split_s;
  logic [3:0]          src_we4_s;
  logic [31:0]         src_wdata_s;
  logic [MEM_AW-1:0]   src_addr1_s;

  logic                mem_req_s, cpu_busy_s, cpu_done_s;
  logic [MEM_AW-1:0]   mem_addr_s;
  logic [3:0]          mem_we4_s;
  logic [31:0]         mem_wdata_s, cpu_rdata_s;

  // Select the access source (live inputs while idle, captured copy otherwise).
  always_comb begin
    src_we_s    = we_r;
    src_split_s = split_r;
    src_we4_s   = we4_r;
    src_wdata_s = wdata_r;
    src_addr1_s = addr1_r;
    if (state_r == IDLE) begin
      src_we_s    = cpu_we;
      src_split_s = (cpu_size == 2'b01) && (cpu_addr[1:0] == 2'b11);
      src_we4_s   = cpu_we4;
      src_wdata_s = cpu_wdata;
      src_addr1_s = cpu_addr[MEM_AW+1:2];
    end else begin
      src_we_s    = we_r;
      src_split_s = split_r;
    end
  end

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (cpu_req) state_s = ISSUE1;
        else         state_s = IDLE;
      end
      ISSUE1: begin
        if (!mem_gnt)      state_s = ISSUE1;
        else if (!we_r)    state_s = WAIT1;
        else if (split_r)  state_s = ISSUE2;
        else               state_s = DONE;
      end
      WAIT1: begin
        if (!mem_rvalid)   state_s = WAIT1;
        else if (split_r)  state_s = ISSUE2;
        else               state_s = DONE;
      end
      ISSUE2: begin
        if (!mem_gnt)      state_s = ISSUE2;
        else if (!we_r)    state_s = WAIT2;
        else               state_s = DONE;
      end
      WAIT2: begin
        if (mem_rvalid) state_s = DONE;
        else            state_s = WAIT2;
      end
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Next values of the registered outputs, derived from the next state.
  always_comb begin
    mem_req_s   = 1'b0;
    mem_we4_s   = 4'b0000;
    mem_addr_s  = mem_addr;
    mem_wdata_s = mem_wdata;
    cpu_rdata_s = cpu_rdata;
    cpu_busy_s  = (state_s != IDLE);
    cpu_done_s  = (state_s == DONE);
    case (state_s)
      ISSUE1: begin
        mem_req_s   = 1'b1;
        mem_addr_s  = src_addr1_s;
        mem_wdata_s = src_wdata_s;
        if (!src_we_s)        mem_we4_s = 4'b0000;
        else if (src_split_s) mem_we4_s = src_we4_s & 4'b1000;
        else                  mem_we4_s = src_we4_s;
      end
      ISSUE2: begin
        mem_req_s   = 1'b1;
        mem_addr_s  = src_addr1_s + ADDR_ONE;  // wraps modulo 2^MEM_AW
        mem_wdata_s = src_wdata_s;
        if (src_we_s) mem_we4_s = src_we4_s & 4'b0001;
        else          mem_we4_s = 4'b0000;
      end
      DONE: begin
        // Load data only changes when a load finishes; stores leave it alone.
        if (state_r == WAIT1)      cpu_rdata_s = mem_rdata;
        else if (state_r == WAIT2) cpu_rdata_s = {first_r[31:8], mem_rdata[7:0]};
        else                       cpu_rdata_s = cpu_rdata;
      end
      default: begin
        mem_req_s = 1'b0;
      end
    endcase
  end

  // State and captured-request registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
      we_r    <= 1'b0;
      split_r <= 1'b0;
      we4_r   <= 4'b0000;
      wdata_r <= 32'h0000_0000;
      addr1_r <= '0;
      first_r <= 32'h0000_0000;
    end else begin
      state_r <= state_s;
      if (state_r == IDLE && cpu_req) begin
        we_r    <= src_we_s;
        split_r <= src_split_s;
        we4_r   <= src_we4_s;
        wdata_r <= src_wdata_s;
        addr1_r <= src_addr1_s;
      end
      if (state_r == WAIT1 && mem_rvalid) begin
        first_r <= mem_rdata;
      end
    end
  end

  // Output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_req   <= 1'b0;
      mem_addr  <= '0;
      mem_we4   <= 4'b0000;
      mem_wdata <= 32'h0000_0000;
      cpu_busy  <= 1'b0;
      cpu_done  <= 1'b0;
      cpu_rdata <= 32'h0000_0000;
    end else begin
      mem_req   <= mem_req_s;
      mem_addr  <= mem_addr_s;
      mem_we4   <= mem_we4_s;
      mem_wdata <= mem_wdata_s;
      cpu_busy  <= cpu_busy_s;
      cpu_done  <= cpu_done_s;
      cpu_rdata <= cpu_rdata_s;
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed testbench for mem_access_ctrl. Inputs change on the falling edge,
// and outputs are sampled there too, half a cycle away from the active edge.
module tb_mem_access_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_req, cpu_we;
  logic [1:0]  cpu_size;
  logic [31:0] cpu_addr;
  logic [3:0]  cpu_we4;
  logic [31:0] cpu_wdata;
  logic        cpu_busy, cpu_done;
  logic [31:0] cpu_rdata;
  logic        mem_req;
  logic [29:0] mem_addr;
  logic [3:0]  mem_we4;
  logic [31:0] mem_wdata;
  logic        mem_gnt, mem_rvalid;
  logic [31:0] mem_rdata;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  mem_access_ctrl #(.MEM_AW(30)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_size(cpu_size), .cpu_addr(cpu_addr),
    .cpu_we4(cpu_we4), .cpu_wdata(cpu_wdata),
    .cpu_busy(cpu_busy), .cpu_done(cpu_done), .cpu_rdata(cpu_rdata),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_we4(mem_we4), .mem_wdata(mem_wdata),
    .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Check the request-side outputs together.
  task automatic check_req(input string tag, input logic req, input logic [31:0] addr,
                           input logic [3:0] we4, input logic [31:0] wdata);
    check({tag, ".mem_req"},   {31'd0, mem_req},  {31'd0, req});
    check({tag, ".mem_addr"},  {2'b00, mem_addr}, addr);
    check({tag, ".mem_we4"},   {28'd0, mem_we4},  {28'd0, we4});
    check({tag, ".mem_wdata"}, mem_wdata,         wdata);
  endtask

  task automatic cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic request(input logic we, input logic [1:0] size, input logic [31:0] addr,
                         input logic [3:0] we4, input logic [31:0] wdata);
    cpu_req = 1'b1; cpu_we = we; cpu_size = size; cpu_addr = addr;
    cpu_we4 = we4; cpu_wdata = wdata;
  endtask

  initial begin
    rst = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_size = 2'b00; cpu_addr = 32'h0;
    cpu_we4 = 4'b0000; cpu_wdata = 32'h0; mem_gnt = 1'b0; mem_rvalid = 1'b0;
    mem_rdata = 32'h0;
    #2;
    check_req("reset", 1'b0, 32'h0, 4'b0000, 32'h0);
    check("reset.busy",  {31'd0, cpu_busy}, 32'd0);
    check("reset.done",  {31'd0, cpu_done}, 32'd0);
    check("reset.rdata", cpu_rdata, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // SW 0x100, immediate grant: done in cycle 2.
    request(1'b1, 2'b10, 32'h0000_0100, 4'b1111, 32'hDEAD_BEEF);
    cycle();                                   // cycle 1: ISSUE1
    cpu_req = 1'b0;
    check_req("sw.c1", 1'b1, 32'h40, 4'b1111, 32'hDEAD_BEEF);
    check("sw.c1.busy", {31'd0, cpu_busy}, 32'd1);
    check("sw.c1.done", {31'd0, cpu_done}, 32'd0);
    mem_gnt = 1'b1;
    cycle();                                   // cycle 2: DONE
    mem_gnt = 1'b0;
    check("sw.c2.done", {31'd0, cpu_done}, 32'd1);
    check("sw.c2.req",  {31'd0, mem_req},  32'd0);
    cycle();
    check("sw.c3.done", {31'd0, cpu_done}, 32'd0);
    check("sw.c3.busy", {31'd0, cpu_busy}, 32'd0);

    // LW 0x104; stray rvalid while still in ISSUE1 must be ignored.
    request(1'b0, 2'b10, 32'h0000_0104, 4'b1111, 32'h0);
    cycle();
    cpu_req = 1'b0;
    check_req("lw.c1", 1'b1, 32'h41, 4'b0000, 32'h0);
    mem_rvalid = 1'b1; mem_rdata = 32'hDEAD_0000;
    cycle();
    mem_rvalid = 1'b0;
    check_req("lw.c2", 1'b1, 32'h41, 4'b0000, 32'h0);
    mem_gnt = 1'b1;
    cycle();                                   // WAIT1
    mem_gnt = 1'b0;
    check("lw.wait.req", {31'd0, mem_req}, 32'd0);
    check("lw.wait.busy", {31'd0, cpu_busy}, 32'd1);
    mem_rvalid = 1'b1; mem_rdata = 32'h1122_3344;
    cycle();                                   // DONE
    mem_rvalid = 1'b0; mem_rdata = 32'h0;
    check("lw.done", {31'd0, cpu_done}, 32'd1);
    check("lw.rdata", cpu_rdata, 32'h1122_3344);
    cycle();

    // SH 0x203 split store.
    request(1'b1, 2'b01, 32'h0000_0203, 4'b1001, 32'hBB00_00AA);
    cycle();
    cpu_req = 1'b0;
    check_req("sh.p1", 1'b1, 32'h80, 4'b1000, 32'hBB00_00AA);
    mem_gnt = 1'b1;
    cycle();
    check_req("sh.p2", 1'b1, 32'h81, 4'b0001, 32'hBB00_00AA);
    cycle();                                   // cycle 3: DONE
    mem_gnt = 1'b0;
    check("sh.done", {31'd0, cpu_done}, 32'd1);
    check("sh.req",  {31'd0, mem_req},  32'd0);
    check("sh.rdata.hold", cpu_rdata, 32'h1122_3344);
    cycle();

    // LH 0x203 split load, phase-2 grant delayed 3 cycles with inputs disturbed.
    request(1'b0, 2'b01, 32'h0000_0203, 4'b0000, 32'h5555_AAAA);
    cycle();
    cpu_req = 1'b0;
    check_req("lh.p1", 1'b1, 32'h80, 4'b0000, 32'h5555_AAAA);
    mem_gnt = 1'b1;
    cycle();                                   // WAIT1
    mem_gnt = 1'b0;
    mem_rvalid = 1'b1; mem_rdata = 32'hAA00_0000;
    cycle();                                   // ISSUE2
    mem_rvalid = 1'b0; mem_rdata = 32'h0;
    cpu_addr = 32'h0000_0F00; cpu_we4 = 4'b1111; cpu_wdata = 32'h0; cpu_we = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check_req("lh.p2.stall", 1'b1, 32'h81, 4'b0000, 32'h5555_AAAA);
      cycle();
    end
    check_req("lh.p2.gnt", 1'b1, 32'h81, 4'b0000, 32'h5555_AAAA);
    mem_gnt = 1'b1;
    cycle();                                   // WAIT2
    mem_gnt = 1'b0;
    check("lh.wait2.req", {31'd0, mem_req}, 32'd0);
    mem_rvalid = 1'b1; mem_rdata = 32'h0000_00BB;
    cycle();                                   // DONE, cpu_req held high is ignored
    mem_rvalid = 1'b0; mem_rdata = 32'h0;
    cpu_req = 1'b1;
    check("lh.done", {31'd0, cpu_done}, 32'd1);
    check("lh.rdata", cpu_rdata, 32'hAA00_00BB);
    cycle();                                   // IDLE
    cpu_req = 1'b0;
    check("lh.idle.busy", {31'd0, cpu_busy}, 32'd0);
    check("lh.idle.req",  {31'd0, mem_req},  32'd0);
    cycle();
    check("lh.idle2.busy", {31'd0, cpu_busy}, 32'd0);

    // LH 0xFFFFFFFF wraps in phase 2, then reset during WAIT2.
    request(1'b0, 2'b01, 32'hFFFF_FFFF, 4'b0000, 32'h0);
    cycle();
    cpu_req = 1'b0;
    check_req("wrap.p1", 1'b1, 32'h3FFF_FFFF, 4'b0000, 32'h0);
    mem_gnt = 1'b1;
    cycle();
    mem_gnt = 1'b0;
    mem_rvalid = 1'b1; mem_rdata = 32'h1234_5678;
    cycle();
    mem_rvalid = 1'b0;
    check_req("wrap.p2", 1'b1, 32'h0, 4'b0000, 32'h0);
    mem_gnt = 1'b1;
    cycle();                                   // WAIT2
    mem_gnt = 1'b0;
    check("wrap.wait2.busy", {31'd0, cpu_busy}, 32'd1);
    rst = 1'b1;
    #1;
    check("rst.req",   {31'd0, mem_req},  32'd0);
    check("rst.busy",  {31'd0, cpu_busy}, 32'd0);
    check("rst.rdata", cpu_rdata, 32'h0);
    check("rst.addr",  {2'b00, mem_addr}, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // SB right after reset: accepted on the first edge.
    request(1'b1, 2'b00, 32'h0000_0002, 4'b0100, 32'h00CC_0000);
    cycle();
    cpu_req = 1'b0;
    check_req("sb.p1", 1'b1, 32'h0, 4'b0100, 32'h00CC_0000);
    mem_gnt = 1'b1;
    cycle();
    mem_gnt = 1'b0;
    check("sb.done", {31'd0, cpu_done}, 32'd1);
    check("sb.req",  {31'd0, mem_req},  32'd0);
    cycle();
    check("sb.idle", {31'd0, cpu_busy}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
